// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the two CPU ports, the arbiter and the downstream memory.
// The arbiter takes the slave view; the environment driving requests and memory takes the master view.
interface cpu_mem_arbiter_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 4;

    logic              read_a;
    logic [WORD_W-1:0] address_a;
    logic              resp_a;
    logic [WORD_W-1:0] rdata_a;

    logic              read_b;
    logic              write;
    logic [MASK_W-1:0] wmask;
    logic [WORD_W-1:0] address_b;
    logic [WORD_W-1:0] wdata;
    logic              resp_b;
    logic [WORD_W-1:0] rdata_b;

    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_byte_enable;
    logic              mem_resp;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  read_a, address_a, read_b, write, wmask, address_b, wdata,
        input  mem_resp, mem_rdata,
        output resp_a, rdata_a, resp_b, rdata_b,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    modport master (
        output read_a, address_a, read_b, write, wmask, address_b, wdata,
        output mem_resp, mem_rdata,
        input  resp_a, rdata_a, resp_b, rdata_b,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Two-port (instruction A / data B) arbiter onto a single memory port; fixed B priority on ties.
// Define ARBITER_RR_EN to alternate ties using a last-served flag instead.
module cpu_mem_arbiter (
    input  logic               clk,
    input  logic               reset_n,
    cpu_mem_arbiter_if.slave   bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam logic [MASK_W-1:0] FULL_MASK = MASK_W'(4'hF);

    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B, DONE} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              wr_q, wr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [MASK_W-1:0] be_q, be_d;
    logic              resp_a_q, resp_a_d;
    logic              resp_b_q, resp_b_d;
    logic [WORD_W-1:0] rdata_a_q, rdata_a_d;
    logic [WORD_W-1:0] rdata_b_q, rdata_b_d;

    logic req_a, req_b, prio_b;

    assign req_a = bus.read_a;
    assign req_b = bus.read_b | bus.write;

`ifdef ARBITER_RR_EN
    // Last-served flag: 1 means B was served last, so A wins the next tie.
    logic last_b_q, last_b_d;

    assign prio_b = ~last_b_q;

    always_comb begin
        last_b_d = last_b_q;
        if (bus.mem_resp && (state_q == SERVE_A)) last_b_d = 1'b0;
        if (bus.mem_resp && (state_q == SERVE_B)) last_b_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_b_q <= 1'b0;
        else          last_b_q <= last_b_d;
    end
`else
    assign prio_b = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            wr_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            be_q        <= '0;
            resp_a_q    <= 1'b0;
            resp_b_q    <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wr_q        <= wr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            be_q        <= be_d;
            resp_a_q    <= resp_a_d;
            resp_b_q    <= resp_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    // Strobes are computed one edge ahead so they are registered and follow the latched request.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wr_d        = wr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        be_d        = '0;
        resp_a_d    = 1'b0;
        resp_b_d    = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;

        unique case (state_q)
            IDLE: begin
                if (req_b && (!req_a || prio_b)) begin
                    state_d     = SERVE_B;
                    addr_d      = bus.address_b;
                    wdata_d     = bus.wdata;
                    wmask_d     = bus.wmask;
                    wr_d        = bus.write;
                    mem_write_d = bus.write;
                    mem_read_d  = ~bus.write;
                    be_d        = bus.write ? bus.wmask : FULL_MASK;
                end else if (req_a) begin
                    state_d    = SERVE_A;
                    addr_d     = bus.address_a;
                    wdata_d    = '0;
                    wmask_d    = FULL_MASK;
                    wr_d       = 1'b0;
                    mem_read_d = 1'b1;
                    be_d       = FULL_MASK;
                end
            end
            SERVE_A: begin
                if (bus.mem_resp) begin
                    state_d   = DONE;
                    rdata_a_d = bus.mem_rdata;
                    resp_a_d  = 1'b1;
                end else begin
                    mem_read_d = 1'b1;
                    be_d       = FULL_MASK;
                end
            end
            SERVE_B: begin
                if (bus.mem_resp) begin
                    state_d   = DONE;
                    rdata_b_d = bus.mem_rdata;
                    resp_b_d  = 1'b1;
                end else begin
                    mem_read_d  = ~wr_q;
                    mem_write_d = wr_q;
                    be_d        = wr_q ? wmask_q : FULL_MASK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.resp_a          = resp_a_q;
    assign bus.resp_b          = resp_b_q;
    assign bus.rdata_a         = rdata_a_q;
    assign bus.rdata_b         = rdata_b_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: expected memory accesses and CPU responses are queued
// by the stimulus; a memory model and a response monitor pop and compare them.
module tb_cpu_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    cpu_mem_arbiter_if bus();

    cpu_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } acc_t;

    typedef struct {
        logic        port_b;
        logic [31:0] data;
        logic        chk_data;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   errors = 0;
    bit   stray_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_acc(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                                     input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        acc_t e;
        e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
        exp_acc.push_back(e);
    endfunction

    function automatic void push_rsp(input logic port_b, input logic [31:0] data, input logic chk_data);
        rsp_t r;
        r.port_b = port_b; r.data = data; r.chk_data = chk_data;
        exp_rsp.push_back(r);
    endfunction

    // Memory model: checks each strobe cycle against the expected access, answers after e.lat cycles.
    initial begin : mem_model
        int   cnt;
        acc_t e;
        cnt = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (!reset_n) begin
                cnt = 0;
            end else if (stray_req) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = 32'hBAD0_0BAD;
                stray_req     = 1'b0;
            end else if (bus.mem_read || bus.mem_write) begin
                chk("mem_rw_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
                cnt++;
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got addr %h rd %0b wr %0b expected none at %0t",
                             bus.mem_address, bus.mem_read, bus.mem_write, $time);
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = '0;
                end else begin
                    e = exp_acc[0];
                    chk("mem_write_op", 32'(bus.mem_write), 32'(e.wr));
                    chk("mem_address", bus.mem_address, e.addr);
                    chk("mem_byte_enable", 32'(bus.mem_byte_enable), 32'(e.be));
                    if (e.wr) chk("mem_wdata", bus.mem_wdata, e.wdata);
                    if (cnt >= e.lat) begin
                        bus.mem_resp  = 1'b1;
                        bus.mem_rdata = e.rdata;
                        void'(exp_acc.pop_front());
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Response monitor: every resp pulse must match the next queued expectation.
    initial begin : resp_mon
        rsp_t r;
        forever begin
            @(negedge clk);
            if (reset_n && (bus.resp_a || bus.resp_b)) begin
                chk("resp_exclusive", 32'(bus.resp_a & bus.resp_b), 32'd0);
                chk("done_no_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_a %0b resp_b %0b expected none at %0t",
                             bus.resp_a, bus.resp_b, $time);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("resp_port_b", 32'(bus.resp_b), 32'(r.port_b));
                    if (r.chk_data) chk("resp_rdata", r.port_b ? bus.rdata_b : bus.rdata_a, r.data);
                end
            end
        end
    end

    task automatic req_a(input logic [31:0] addr, output int cyc);
        bus.read_a    = 1'b1;
        bus.address_a = addr;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.resp_a && cyc < 200);
        if (!bus.resp_a) begin
            checks++;
            errors++;
            $display("FAIL req_a_timeout: got no resp_a expected resp_a for addr %h", addr);
        end
        bus.read_a    = 1'b0;
        bus.address_a = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic req_b(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, output int cyc);
        bus.read_b    = rd;
        bus.write     = wr;
        bus.address_b = addr;
        bus.wdata     = wdata;
        bus.wmask     = mask;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.resp_b && cyc < 200);
        if (!bus.resp_b) begin
            checks++;
            errors++;
            $display("FAIL req_b_timeout: got no resp_b expected resp_b for addr %h", addr);
        end
        bus.read_b    = 1'b0;
        bus.write     = 1'b0;
        bus.address_b = '0;
        bus.wdata     = '0;
        bus.wmask     = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_resp_a"}, 32'(bus.resp_a), 32'd0);
        chk({tag, "_resp_b"}, 32'(bus.resp_b), 32'd0);
        chk({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        chk({tag, "_mem_be"}, 32'(bus.mem_byte_enable), 32'd0);
        chk({tag, "_mem_address"}, bus.mem_address, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_rdata_a"}, bus.rdata_a, 32'd0);
        chk({tag, "_rdata_b"}, bus.rdata_b, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c;
        int w;
        bus.read_a = 1'b0; bus.address_a = '0;
        bus.read_b = 1'b0; bus.write = 1'b0; bus.wmask = '0; bus.address_b = '0; bus.wdata = '0;
        reset_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Instruction read granted on the first edge after reset, memory answers in the 2nd strobe cycle.
        push_acc(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h0000_0013, 2);
        push_rsp(1'b0, 32'h0000_0013, 1'b1);
        req_a(32'h0000_0040, c);
        chk("latency_a", 32'(c), 32'd3);

        // Masked data write.
        push_acc(1'b1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1);
        push_rsp(1'b1, 32'h0, 1'b0);
        req_b(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, c);
        chk("latency_b_write", 32'(c), 32'd2);

        // read_b together with write is a write.
        push_acc(1'b1, 32'h0000_0200, 4'b1100, 32'h1234_5678, 32'h0, 3);
        push_rsp(1'b1, 32'h0, 1'b0);
        req_b(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b1100, c);

        push_acc(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'hCAFE_F00D, 1);
        push_rsp(1'b1, 32'hCAFE_F00D, 1'b1);
        req_b(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, c);

        push_acc(1'b0, 32'h0000_0340, 4'hF, 32'h0, 32'h0000_5A5A, 2);
        push_rsp(1'b0, 32'h0000_5A5A, 1'b1);
        req_a(32'h0000_0340, c);

        // Both ports requesting from the same cycle: B, A, B, A.
        push_acc(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h1111_0001, 2);
        push_rsp(1'b1, 32'h1111_0001, 1'b1);
        push_acc(1'b0, 32'h0000_0500, 4'hF, 32'h0, 32'h2222_0002, 1);
        push_rsp(1'b0, 32'h2222_0002, 1'b1);
        push_acc(1'b0, 32'h0000_0404, 4'hF, 32'h0, 32'h1111_0003, 3);
        push_rsp(1'b1, 32'h1111_0003, 1'b1);
        push_acc(1'b0, 32'h0000_0504, 4'hF, 32'h0, 32'h2222_0004, 2);
        push_rsp(1'b0, 32'h2222_0004, 1'b1);
        fork
            begin
                int cb;
                req_b(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, cb);
                req_b(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'h0, cb);
            end
            begin
                int ca;
                req_a(32'h0000_0500, ca);
                req_a(32'h0000_0504, ca);
            end
        join

        // B served last, then a tie: fixed priority picks B again, round-robin picks A.
        push_acc(1'b0, 32'h0000_0600, 4'hF, 32'h0, 32'h0000_0003, 1);
        push_rsp(1'b1, 32'h0000_0003, 1'b1);
        req_b(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0, c);
`ifdef ARBITER_RR_EN
        push_acc(1'b0, 32'h0000_0700, 4'hF, 32'h0, 32'h0000_0044, 1);
        push_rsp(1'b0, 32'h0000_0044, 1'b1);
        push_acc(1'b0, 32'h0000_0800, 4'hF, 32'h0, 32'h0000_0055, 1);
        push_rsp(1'b1, 32'h0000_0055, 1'b1);
`else
        push_acc(1'b0, 32'h0000_0800, 4'hF, 32'h0, 32'h0000_0055, 1);
        push_rsp(1'b1, 32'h0000_0055, 1'b1);
        push_acc(1'b0, 32'h0000_0700, 4'hF, 32'h0, 32'h0000_0044, 1);
        push_rsp(1'b0, 32'h0000_0044, 1'b1);
`endif
        fork
            begin
                int ca;
                req_a(32'h0000_0700, ca);
            end
            begin
                int cb;
                req_b(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'h0, cb);
            end
        join

        // Requester drops after resp: no second access may follow.
        push_acc(1'b0, 32'h0000_0900, 4'hF, 32'h0, 32'h0000_0900, 1);
        push_rsp(1'b0, 32'h0000_0900, 1'b1);
        req_a(32'h0000_0900, c);
        repeat (4) @(negedge clk);
        chk("no_reserve_strobe", 32'(bus.mem_read | bus.mem_write), 32'd0);
        chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        chk("rdata_a_hold", bus.rdata_a, 32'h0000_0900);
        chk("rdata_b_hold", bus.rdata_b, 32'h0000_0055);

        // Reset while a write is outstanding.
        push_acc(1'b1, 32'h0000_0A00, 4'hF, 32'h0BAD_CAFE, 32'h0, 50);
        bus.write = 1'b1; bus.address_b = 32'h0000_0A00; bus.wdata = 32'h0BAD_CAFE; bus.wmask = 4'hF;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.mem_write && w < 20);
        chk("serve_b_reached", 32'(bus.mem_write), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        exp_acc.delete();
        exp_rsp.delete();
        bus.write = 1'b0; bus.address_b = '0; bus.wdata = '0; bus.wmask = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        stray_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_resp_b", 32'(bus.resp_b), 32'd0);
        chk("post_reset_rdata_b", bus.rdata_b, 32'd0);
        chk("post_reset_idle", 32'(bus.mem_read | bus.mem_write), 32'd0);

        push_acc(1'b0, 32'h0000_0B00, 4'hF, 32'h0, 32'h0000_7777, 2);
        push_rsp(1'b0, 32'h0000_7777, 1'b1);
        req_a(32'h0000_0B00, c);
        chk("latency_a_after_reset", 32'(c), 32'd3);

        repeat (3) @(negedge clk);
        chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
